// File: rtl/axis_frame_align_pkg.sv
// axis_frame_align_pkg: shared state encoding and error-counter limits for axis_frame_align
package axis_frame_align_pkg;
  typedef enum logic {HUNT, PASS} state_t;
  localparam int ERRCNT_BITS = 16;
  localparam logic [63:0] ERRCNT_MAX = '1;
endpackage

// File: rtl/axis_frame_align_pos.sv
// frame_pos_cnt: latched frame size, column/row position and expected marker decode
module frame_pos_cnt #(
  parameter int C_IMG_WBITS = 12,
  parameter int C_IMG_HBITS = 12
)(
  input  logic                   f2s_aclk,
  input  logic                   resetn,
  input  logic                   load,
  input  logic                   advance,
  input  logic [C_IMG_WBITS-1:0] width,
  input  logic [C_IMG_HBITS-1:0] height,
  output logic                   exp_sof,
  output logic                   exp_eol,
  output logic                   load_eol
);
  logic [C_IMG_WBITS-1:0] w_lat, col, cw, cb, nc;
  logic [C_IMG_HBITS-1:0] h_lat, row, ch, rb, nr;
  logic eol_b;
  // A load beat occupies position (0,0) itself, so the counters step past it immediately
  always_comb begin
    cw = load ? width : w_lat;
    ch = load ? height : h_lat;
    cb = load ? '0 : col;
    rb = load ? '0 : row;
    eol_b = cb == cw - 1'b1;
    nc = eol_b ? '0 : cb + 1'b1;
    nr = !eol_b ? rb : rb == ch - 1'b1 ? '0 : rb + 1'b1;
  end
  assign exp_sof = col == '0 && row == '0;
  assign exp_eol = col == w_lat - 1'b1;
  assign load_eol = width == C_IMG_WBITS'(1);
  always_ff @(posedge f2s_aclk)
    if (!resetn) begin
      w_lat <= '0;
      h_lat <= '0;
      col <= '0;
      row <= '0;
    end else if (load || advance) begin
      w_lat <= cw;
      h_lat <= ch;
      col <= nc;
      row <= nr;
    end
endmodule

// File: rtl/axis_frame_align.sv
// axis_frame_align: realigns an AXIS pixel stream to img_width x img_height frames with regenerated markers
// AXIS_FRAME_ALIGN_ERRCNT_EN adds saturating sof/eol error counters
module axis_frame_align
  import axis_frame_align_pkg::*;
#(
  parameter int C_PIXEL_WIDTH = 8,
  parameter int C_IMG_WBITS = 12,
  parameter int C_IMG_HBITS = 12
`ifdef AXIS_FRAME_ALIGN_ERRCNT_EN
  , parameter int C_ERRCNT_BITS = ERRCNT_BITS
`endif
)(
  input  logic                     f2s_aclk,
  input  logic                     resetn,
  input  logic [C_IMG_WBITS-1:0]   img_width,
  input  logic [C_IMG_HBITS-1:0]   img_height,
  input  logic                     s_axis_tvalid,
  output logic                     s_axis_tready,
  input  logic [C_PIXEL_WIDTH-1:0] s_axis_tdata,
  input  logic                     s_axis_tuser,
  input  logic                     s_axis_tlast,
  output logic                     m_axis_tvalid,
  input  logic                     m_axis_tready,
  output logic [C_PIXEL_WIDTH-1:0] m_axis_tdata,
  output logic                     m_axis_tuser,
  output logic                     m_axis_tlast,
  output logic                     in_sync,
  output logic                     sof_err,
  output logic                     eol_err
`ifdef AXIS_FRAME_ALIGN_ERRCNT_EN
  , output logic [C_ERRCNT_BITS-1:0] sof_err_cnt
  , output logic [C_ERRCNT_BITS-1:0] eol_err_cnt
`endif
);
  state_t state;
  logic acc, pass, zero, load, advance, fwd, exp_sof, exp_eol, load_eol;
  assign s_axis_tready = ~m_axis_tvalid | m_axis_tready;
  assign acc = s_axis_tvalid & s_axis_tready;
  assign pass = state == PASS;
  assign zero = img_width == '0 || img_height == '0;
  assign load = acc & s_axis_tuser & ~zero;
  assign advance = acc & pass & ~s_axis_tuser & ~exp_sof;
  assign fwd = load | advance;
  assign in_sync = pass;
  frame_pos_cnt #(.C_IMG_WBITS(C_IMG_WBITS), .C_IMG_HBITS(C_IMG_HBITS)) u_pos (
    .f2s_aclk(f2s_aclk),
    .resetn(resetn),
    .load(load),
    .advance(advance),
    .width(img_width),
    .height(img_height),
    .exp_sof(exp_sof),
    .exp_eol(exp_eol),
    .load_eol(load_eol)
  );
  // Every accepted beat that is not forwarded leaves the block hunting for the next frame start
  always_ff @(posedge f2s_aclk)
    if (!resetn) begin
      state <= HUNT;
      m_axis_tvalid <= 1'b0;
      m_axis_tdata <= '0;
      m_axis_tuser <= 1'b0;
      m_axis_tlast <= 1'b0;
      sof_err <= 1'b0;
      eol_err <= 1'b0;
    end else begin
      if (acc) state <= fwd ? PASS : HUNT;
      m_axis_tvalid <= acc ? fwd : m_axis_tvalid & ~m_axis_tready;
      if (fwd) begin
        m_axis_tdata <= s_axis_tdata;
        m_axis_tuser <= load;
        m_axis_tlast <= load ? load_eol : exp_eol;
      end
      sof_err <= acc & pass & (s_axis_tuser != exp_sof);
      eol_err <= acc & pass & (s_axis_tlast != exp_eol);
    end
`ifdef AXIS_FRAME_ALIGN_ERRCNT_EN
  always_ff @(posedge f2s_aclk)
    if (!resetn) begin
      sof_err_cnt <= '0;
      eol_err_cnt <= '0;
    end else begin
      if (sof_err && sof_err_cnt != C_ERRCNT_BITS'(ERRCNT_MAX)) sof_err_cnt <= sof_err_cnt + 1'b1;
      if (eol_err && eol_err_cnt != C_ERRCNT_BITS'(ERRCNT_MAX)) eol_err_cnt <= eol_err_cnt + 1'b1;
    end
`endif
endmodule

// File: tb/tb_axis_frame_align.sv
// tb_axis_frame_align: scoreboard bench with a linear-index frame model for axis_frame_align
module tb_axis_frame_align;
  logic clk = 0, resetn = 0;
  logic [11:0] img_width = 12'd4, img_height = 12'd2;
  logic s_valid = 0, s_ready, s_user = 0, s_last = 0;
  logic [7:0] s_data = 0;
  logic m_valid, m_ready = 1, m_user, m_last, in_sync, sof_err, eol_err;
  logic [7:0] m_data;
`ifdef AXIS_FRAME_ALIGN_ERRCNT_EN
  logic [15:0] sof_err_cnt, eol_err_cnt;
`endif
  int checks = 0, errors = 0, mode = 0;
  int sync = 0, w = 0, h = 0, p = 0, pend = 0, was_rst = 1, hold = 0, n_se = 0, n_ee = 0;
  logic [9:0] exp_q[$];
  logic [9:0] held;

  always #5 clk = ~clk;

  axis_frame_align dut (
    .f2s_aclk(clk), .resetn(resetn), .img_width(img_width), .img_height(img_height),
    .s_axis_tvalid(s_valid), .s_axis_tready(s_ready), .s_axis_tdata(s_data),
    .s_axis_tuser(s_user), .s_axis_tlast(s_last),
    .m_axis_tvalid(m_valid), .m_axis_tready(m_ready), .m_axis_tdata(m_data),
    .m_axis_tuser(m_user), .m_axis_tlast(m_last),
    .in_sync(in_sync), .sof_err(sof_err), .eol_err(eol_err)
`ifdef AXIS_FRAME_ALIGN_ERRCNT_EN
    , .sof_err_cnt(sof_err_cnt), .eol_err_cnt(eol_err_cnt)
`endif
  );

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Frame position is a single beat index p in [0, w*h); markers follow from p by arithmetic
  task automatic model(input logic [7:0] d, input logic u, input logic l);
    logic es, el;
    if (sync != 0) begin
      es = p == 0;
      el = (p % w) == (w - 1);
      pend = {u != es, l != el};
      n_se += int'(u != es);
      n_ee += int'(l != el);
    end
    if (u) begin
      if (img_width == 0 || img_height == 0) sync = 0;
      else begin
        w = int'(img_width);
        h = int'(img_height);
        exp_q.push_back({d, 1'b1, w == 1});
        p = 1 % (w * h);
        sync = 1;
      end
    end else if (sync != 0) begin
      if (p == 0) sync = 0;
      else begin
        exp_q.push_back({d, 1'b0, (p % w) == (w - 1)});
        p = (p + 1) % (w * h);
      end
    end
  endtask

  always @(negedge clk) begin
    if (!resetn) begin
      exp_q.delete();
      sync = 0; pend = 0; hold = 0; was_rst = 1; n_se = 0; n_ee = 0;
    end else begin
      if (was_rst != 0) begin
        chk("reset_state", {m_valid, m_data, m_user, m_last, in_sync, sof_err, eol_err}, 0);
`ifdef AXIS_FRAME_ALIGN_ERRCNT_EN
        chk("reset_cnt", {sof_err_cnt, eol_err_cnt}, 0);
`endif
      end
      was_rst = 0;
      chk("err_pulse", {sof_err, eol_err}, pend);
      chk("in_sync", in_sync, sync);
      if (hold != 0) chk("hold", {m_valid, m_data, m_user, m_last}, {1'b1, held});
      if (m_valid && m_ready) begin
        if (exp_q.size() == 0) chk("extra_beat", {m_data, m_user, m_last}, -1);
        else chk("beat", {m_data, m_user, m_last}, exp_q.pop_front());
      end
      hold = int'(m_valid && !m_ready);
      held = {m_data, m_user, m_last};
      chk("s_ready", s_ready, !m_valid || m_ready);
      pend = 0;
      if (s_valid && s_ready) model(s_data, s_user, s_last);
    end
  end

  initial forever begin
    @(posedge clk);
    #1;
    m_ready = mode == 0 ? 1'b1 : mode == 1 ? 1'($urandom_range(0, 1)) : ~m_ready;
  end

  task automatic send(input logic [7:0] d, input logic u, input logic l);
    int n;
    s_valid = 1; s_data = d; s_user = u; s_last = l;
    for (n = 0; n < 200; n++) begin
      @(negedge clk);
      if (s_ready) break;
    end
    if (n == 200) chk("accept_timeout", 1, 0);
    @(posedge clk);
    #1;
    s_valid = 0;
  endtask

  task automatic frame(input int fw, input int fh, input int rnd);
    img_width = 12'(fw);
    img_height = 12'(fh);
    for (int i = 0; i < fw * fh; i++) begin
      logic u, l;
      u = i == 0;
      l = (i % fw) == (fw - 1);
      if (rnd != 0 && $urandom_range(0, 19) == 0) u = ~u;
      if (rnd != 0 && $urandom_range(0, 19) == 0) l = ~l;
      if (rnd != 0 && $urandom_range(0, 3) == 0) begin @(posedge clk); #1; end
      send(8'($urandom), u, l);
    end
  endtask

  task automatic pulse_reset();
    @(posedge clk); #1 resetn = 0;
    @(posedge clk); #1 resetn = 1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(posedge clk);
    #1 resetn = 1;
    frame(4, 2, 0);
    mode = 2;
    frame(4, 2, 0);
    frame(4, 2, 0);
    mode = 0;
    for (int i = 0; i < 5; i++) send(8'(8'h20 + i), i == 0, i == 3);
    send(8'h25, 1, 0);
    for (int k = 1; k < 8; k++) send(8'(8'h30 + k), 0, k == 3 || k == 7);
    for (int i = 0; i < 8; i++) send(8'(8'h40 + i), i == 0, i == 7);
    pulse_reset();
    for (int i = 0; i < 3; i++) send(8'(8'h50 + i), 0, i == 2);
    frame(4, 2, 0);
    for (int i = 0; i < 4; i++) send(8'(8'h60 + i), i == 0, i == 3);
    pulse_reset();
    frame(4, 2, 0);
    img_width = 0;
    send(8'h70, 1, 0);
    send(8'h71, 0, 0);
    img_width = 4; img_height = 0;
    send(8'h72, 1, 0);
    frame(3, 1, 0);
    frame(1, 3, 0);
    mode = 1;
    for (int f = 0; f < 40; f++) frame($urandom_range(1, 5), $urandom_range(1, 3), 1);
    mode = 0;
    repeat (10) @(posedge clk);
    #1;
    chk("drain", exp_q.size(), 0);
`ifdef AXIS_FRAME_ALIGN_ERRCNT_EN
    chk("sof_cnt", sof_err_cnt, n_se);
    chk("eol_cnt", eol_err_cnt, n_ee);
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
